// File: rtl/input_spike_encoder_if.sv
// rtl/input_spike_encoder_if.sv - Bus bundle for the input spike encoder
//
// Groups the configuration, tick-control and FIFO-push signals of the encoder.
//   M : channel index width
//   R : intensity / accumulator width
// Modports:
//   slave  : encoder side (receives cfg/start/clear/full, drives push/status)
//   master : controller side (drives cfg/start/clear/full, observes push/status)
interface input_spike_encoder_if #(
  parameter int M = 8,
  parameter int R = 8
);
  logic         cfg_we_i;
  logic [M-1:0] cfg_addr_i;
  logic [R-1:0] cfg_wdata_i;
  logic         start_i;
  logic [M-1:0] max_neuron_i;
  logic         clear_acc_i;
  logic         FIFO_w_en_o;
  logic [M-1:0] FIFO_w_data_o;
  logic         FIFO_full_i;
  logic         spikecore_done_o;
  logic         busy_o;

  modport slave (
    input  cfg_we_i,
    input  cfg_addr_i,
    input  cfg_wdata_i,
    input  start_i,
    input  max_neuron_i,
    input  clear_acc_i,
    input  FIFO_full_i,
    output FIFO_w_en_o,
    output FIFO_w_data_o,
    output spikecore_done_o,
    output busy_o
  );

  modport master (
    output cfg_we_i,
    output cfg_addr_i,
    output cfg_wdata_i,
    output start_i,
    output max_neuron_i,
    output clear_acc_i,
    output FIFO_full_i,
    input  FIFO_w_en_o,
    input  FIFO_w_data_o,
    input  spikecore_done_o,
    input  busy_o
  );
endinterface

// File: rtl/input_spike_encoder.sv
// rtl/input_spike_encoder.sv - Rate-coded input spike encoder with FIFO push
//
// Each tick scans channels 0..max, adding the channel intensity into its
// accumulator; an overflow (carry out) emits one spike, pushed as the channel
// index into a downstream FIFO. A carry that meets a full FIFO stalls the scan.
// Ports:
//   CLK  : clock, all state on rising edge
//   RST  : asynchronous active-high reset
//   bus  : input_spike_encoder_if.slave
//          cfg_we_i/cfg_addr_i/cfg_wdata_i : intensity write port
//          start_i/max_neuron_i            : tick start pulse and last index
//          clear_acc_i                     : zero all accumulators (not in SCAN)
//          FIFO_w_en_o/FIFO_w_data_o       : spike push strobe and channel index
//          FIFO_full_i                     : downstream back-pressure
//          spikecore_done_o                : level, tick scan complete
//          busy_o                          : scan in progress
module input_spike_encoder #(
  parameter int N          = 256,
  parameter int M          = 8,
  parameter int INPUT_RESO = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input_spike_encoder_if.slave  bus
);

  localparam int R = INPUT_RESO;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [M-1:0] idx_q, idx_d;
  logic [M-1:0] max_q, max_d;

  logic [R-1:0] intensity [N];
  logic [R-1:0] acc       [N];

  logic [R:0]   sum;
  logic         carry;
  logic         advance;
  logic         push;

  // One extra bit so the overflow of acc + intensity is the spike condition.
  always_comb begin
    sum   = {1'b0, acc[idx_q]} + {1'b0, intensity[idx_q]};
    carry = sum[R];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    max_d   = max_q;
    advance = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          state_d = SCAN;
          idx_d   = '0;
          max_d   = bus.max_neuron_i;
        end
      end
      SCAN: begin
        // A spike that cannot be pushed holds the whole scan in place so
        // that no spike is lost and none is emitted twice.
        if (!(carry && bus.FIFO_full_i)) begin
          advance = 1'b1;
          push    = carry;
          if (idx_q == max_q) begin
            // Stop on the last index rather than incrementing, so a scan up
            // to N-1 never wraps back to channel 0.
            state_d = DONE;
          end else begin
            idx_d = idx_q + M'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
    end
  end

  // Intensity writes are accepted in any state. The scan reads the registered
  // value, so a write to the channel being scanned only affects the next tick.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        intensity[i] <= '0;
      end
    end else if (bus.cfg_we_i) begin
      intensity[bus.cfg_addr_i] <= bus.cfg_wdata_i;
    end
  end

  // advance is only ever set in SCAN, so it never collides with a clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        acc[i] <= '0;
      end
    end else if (advance) begin
      acc[idx_q] <= sum[R-1:0];
    end else if (bus.clear_acc_i && (state_q != SCAN)) begin
      for (int i = 0; i < N; i++) begin
        acc[i] <= '0;
      end
    end
  end

  assign bus.FIFO_w_en_o      = push;
  assign bus.FIFO_w_data_o    = push ? idx_q : '0;
  assign bus.spikecore_done_o = (state_q == DONE);
  assign bus.busy_o           = (state_q == SCAN);

endmodule

// File: tb/tb_input_spike_encoder.sv
// tb/tb_input_spike_encoder.sv - Scoreboard bench for input_spike_encoder
module tb_input_spike_encoder;

  localparam int N = 256;
  localparam int M = 8;
  localparam int R = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  input_spike_encoder_if #(.M(M), .R(R)) bus ();

  input_spike_encoder #(.N(N), .M(M), .INPUT_RESO(R)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  int           exp_q [$];
  logic [R-1:0] int_m [N];
  logic [R-1:0] acc_m [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every push seen at the falling edge is matched against the scoreboard.
  always @(negedge CLK) begin
    if (RST === 1'b0 && bus.FIFO_w_en_o === 1'b1) begin
      check("push_while_full", {31'b0, bus.FIFO_full_i}, 32'd0);
      if (exp_q.size() == 0)
        check("unexpected_push", {24'b0, bus.FIFO_w_data_o}, 32'hFFFF_FFFF);
      else
        check("push_idx", {24'b0, bus.FIFO_w_data_o}, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      int_m[i] = '0;
      acc_m[i] = '0;
    end
    exp_q.delete();
  endfunction

  function automatic void model_tick(input int mx);
    logic [R:0] s;
    for (int i = 0; i <= mx; i++) begin
      s = {1'b0, acc_m[i]} + {1'b0, int_m[i]};
      if (s[R]) exp_q.push_back(i);
      acc_m[i] = s[R-1:0];
    end
  endfunction

  task automatic do_reset();
    RST = 1'b1;
    cyc(2);
    RST = 1'b0;
    model_reset();
    cyc(1);
  endtask

  task automatic cfg_write(input int a, input int d);
    bus.cfg_we_i    = 1'b1;
    bus.cfg_addr_i  = M'(a);
    bus.cfg_wdata_i = R'(d);
    cyc(1);
    bus.cfg_we_i    = 1'b0;
    int_m[a]        = R'(d);
  endtask

  // ev_kind: 0 none, 1 intensity write, 2 start pulse, 3 clear pulse (all mid-scan)
  task automatic do_tick(input string tag, input int mx, input int stall_at, input int stall_len,
                         input int ev_kind, input int ev_at, input int wa, input int wd);
    int n;
    n = 0;
    model_tick(mx);
    bus.max_neuron_i = M'(mx);
    bus.start_i      = 1'b1;
    cyc(1);
    bus.start_i      = 1'b0;
    bus.max_neuron_i = '0;
    check({tag, "_busy_after_start"}, {31'b0, bus.busy_o}, 32'd1);
    check({tag, "_done_fell"}, {31'b0, bus.spikecore_done_o}, 32'd0);
    fork
      begin
        while (bus.spikecore_done_o !== 1'b1 && n < 2000) begin
          cyc(1);
          n++;
        end
      end
      begin
        if (stall_len > 0) begin
          cyc(stall_at);
          bus.FIFO_full_i = 1'b1;
          cyc(stall_len);
          bus.FIFO_full_i = 1'b0;
        end
      end
      begin
        if (ev_kind != 0) begin
          cyc(ev_at);
          case (ev_kind)
            1: begin
              bus.cfg_we_i    = 1'b1;
              bus.cfg_addr_i  = M'(wa);
              bus.cfg_wdata_i = R'(wd);
              cyc(1);
              bus.cfg_we_i    = 1'b0;
              int_m[wa]       = R'(wd);
            end
            2: begin
              bus.start_i = 1'b1;
              cyc(1);
              bus.start_i = 1'b0;
            end
            default: begin
              bus.clear_acc_i = 1'b1;
              cyc(1);
              bus.clear_acc_i = 1'b0;
            end
          endcase
        end
      end
    join
    check({tag, "_latency"}, n, mx + 1 + stall_len);
    check({tag, "_busy_done"}, {31'b0, bus.busy_o}, 32'd0);
    check({tag, "_pushes_left"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bus.cfg_we_i     = 1'b0;
    bus.cfg_addr_i   = '0;
    bus.cfg_wdata_i  = '0;
    bus.start_i      = 1'b0;
    bus.max_neuron_i = '0;
    bus.clear_acc_i  = 1'b0;
    bus.FIFO_full_i  = 1'b0;
    model_reset();

    // Reset state
    #1 RST = 1'b1;
    #2;
    check("rst_busy", {31'b0, bus.busy_o}, 32'd0);
    check("rst_done", {31'b0, bus.spikecore_done_o}, 32'd0);
    check("rst_wen", {31'b0, bus.FIFO_w_en_o}, 32'd0);
    check("rst_wdata", {24'b0, bus.FIFO_w_data_o}, 32'd0);
    cyc(2);
    RST = 1'b0;
    cyc(5);
    check("idle_wait_busy", {31'b0, bus.busy_o}, 32'd0);

    // Single half-scale channel: spike every second tick
    cfg_write(3, 128);
    do_tick("half_t1", 7, 0, 0, 0, 0, 0, 0);
    do_tick("half_t2", 7, 0, 0, 0, 0, 0, 0);
    check("half_acc3", {24'b0, dut.acc[3]}, {24'b0, acc_m[3]});

    // Full-scale channel: spike on every tick after the first
    do_reset();
    cfg_write(0, 255);
    for (int t = 0; t < 3; t++) begin
      do_tick("full", 3, 0, 0, 0, 0, 0, 0);
      check("full_acc0", {24'b0, dut.acc[0]}, {24'b0, acc_m[0]});
    end

    // FIFO back-pressure on a carry at idx 5
    do_reset();
    cfg_write(5, 200);
    do_tick("stall_t1", 7, 0, 0, 0, 0, 0, 0);
    do_tick("stall_t2", 7, 5, 5, 0, 0, 0, 0);

    // Intensity write to the channel being scanned
    do_reset();
    do_tick("wr_t1", 7, 0, 0, 1, 2, 2, 255);
    check("wr_acc2_t1", {24'b0, dut.acc[2]}, {24'b0, acc_m[2]});
    do_tick("wr_t2", 7, 0, 0, 0, 0, 0, 0);
    check("wr_acc2_t2", {24'b0, dut.acc[2]}, {24'b0, acc_m[2]});

    // start/clear pulses during SCAN are ignored; clear in DONE works
    do_reset();
    cfg_write(1, 200);
    do_tick("ign_t1", 7, 0, 0, 0, 0, 0, 0);
    do_tick("ign_start", 7, 0, 0, 2, 3, 0, 0);
    do_tick("ign_clear", 7, 0, 0, 3, 2, 0, 0);
    check("ign_acc1", {24'b0, dut.acc[1]}, {24'b0, acc_m[1]});
    bus.clear_acc_i = 1'b1;
    cyc(1);
    bus.clear_acc_i = 1'b0;
    for (int i = 0; i < N; i++) acc_m[i] = '0;
    check("clear_done_acc1", {24'b0, dut.acc[1]}, {24'b0, acc_m[1]});

    // Full-range scan ends on N-1 without wrapping
    do_reset();
    cfg_write(N - 1, 255);
    cfg_write(0, 255);
    do_tick("wide_t1", N - 1, 0, 0, 0, 0, 0, 0);
    do_tick("wide_t2", N - 1, 0, 0, 0, 0, 0, 0);
    check("wide_acc0", {24'b0, dut.acc[0]}, {24'b0, acc_m[0]});

    // Random intensities and scan lengths
    do_reset();
    for (int i = 0; i < 16; i++) cfg_write(i, $urandom_range(255, 0));
    for (int t = 0; t < 6; t++) do_tick("rand", $urandom_range(15, 0), 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i += 5)
      check("rand_acc", {24'b0, dut.acc[i]}, {24'b0, acc_m[i]});

    // Reset asserted mid-scan
    do_reset();
    cfg_write(6, 200);
    do_tick("abort_t1", 7, 0, 0, 0, 0, 0, 0);
    bus.max_neuron_i = M'(7);
    bus.start_i      = 1'b1;
    cyc(1);
    bus.start_i      = 1'b0;
    cyc(3);
    #3 RST = 1'b1;
    #1;
    check("abort_busy", {31'b0, bus.busy_o}, 32'd0);
    check("abort_done", {31'b0, bus.spikecore_done_o}, 32'd0);
    check("abort_wen", {31'b0, bus.FIFO_w_en_o}, 32'd0);
    check("abort_wdata", {24'b0, bus.FIFO_w_data_o}, 32'd0);
    cyc(2);
    RST = 1'b0;
    model_reset();
    check("abort_acc6", {24'b0, dut.acc[6]}, {24'b0, acc_m[6]});
    check("abort_int6", {24'b0, dut.intensity[6]}, {24'b0, int_m[6]});
    cyc(20);
    check("abort_idle_busy", {31'b0, bus.busy_o}, 32'd0);
    check("abort_idle_done", {31'b0, bus.spikecore_done_o}, 32'd0);
    do_tick("abort_t2", 7, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
